// File: rtl/nrs_gold_pkg.sv
// rtl/nrs_gold_pkg.sv - shared constants and FSM state type for the NRS Gold-sequence generator
//
// Purpose : feedback masks and load values for the two 31-bit LFSRs of the
//           Gold sequence c(n) = x1(n+NC) ^ x2(n+NC), plus the generator FSM states.
// Ports   : none (package).

package nrs_gold_pkg;

    // Feedback masks on s[30:0]; s[0] is the oldest bit x(n).
    localparam logic [30:0] X1_TAPS    = 31'h0000_0009;
    localparam logic [30:0] X2_TAPS    = 31'h0000_000F;

    // x1(0) = 1, x1(1..30) = 0
    localparam logic [30:0] X1_INIT    = 31'h0000_0001;

    localparam int          NC_DEFAULT = 1600;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } gold_state_t;

endpackage

// File: rtl/nrs_lfsr31_par.sv
// rtl/nrs_lfsr31_par.sv - 31-bit Fibonacci LFSR advancing P positions per clock
//
// Purpose : holds s[30:0] with s[0] = x(n) (oldest) and s[30] = x(n+30).
//           One advance produces x(n+31 .. n+30+P) and drops x(n .. n+P-1).
// Ports   : clk        - clock
//           rst        - asynchronous active-low reset (register clears to 0)
//           i_load     - load i_load_val (has priority over i_adv)
//           i_load_val - value to load
//           i_adv      - advance the register by P positions
//           o_state    - current register contents

module nrs_lfsr31_par
    import nrs_gold_pkg::*;
#(
    parameter int          P    = 8,
    parameter logic [30:0] TAPS = X1_TAPS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [30:0] i_load_val,
    input  logic        i_adv,
    output logic [30:0] o_state
);

    logic [30:0] r_state;
    logic [30:0] w_next;

    // Unrolled feedback chain: e[0..30] is the current window and each new
    // bit e[31+k] depends only on e[k..k+3], which already exist because the
    // highest tap is 3 and P stays below 29.
    function automatic logic [30:0] f_advance(input logic [30:0] s);
        logic [30+P:0] e;
        logic          fb;
        e       = '0;
        e[30:0] = s;
        for (int k = 0; k < P; k++) begin
            fb = 1'b0;
            for (int i = 0; i < 31; i++) begin
                if (TAPS[i]) begin
                    fb = fb ^ e[k+i];
                end
            end
            e[31+k] = fb;
        end
        return e[30+P:P];
    endfunction

    always_comb begin
        w_next = f_advance(r_state);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= i_load_val;
        end else if (i_adv) begin
            r_state <= w_next;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/nrs_gold_seq_gen.sv
// rtl/nrs_gold_seq_gen.sv - NB-IoT NRS Gold-sequence generator, P bits per clock
//
// Purpose : loads x1/x2 on start, runs the NC-bit warm-up internally, then
//           streams len words of c(n) over a valid/ready handshake.
// Ports   : clk        - clock
//           rst        - asynchronous active-low reset
//           start      - one-cycle pulse, loads seed and (re)starts a sequence
//           c_init     - x2 seed, sampled with start
//           len        - number of P-bit words, sampled with start
//           dout       - output word, dout[0] = earliest bit; zero when not valid
//           dout_valid - dout holds a word
//           dout_ready - consumer accepts dout
//           busy       - high in WARMUP or RUN
//           done       - one-cycle pulse after the last word is accepted

module nrs_gold_seq_gen
    import nrs_gold_pkg::*;
#(
    parameter int P    = 8,
    parameter int NC   = NC_DEFAULT,
    parameter int LENW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [30:0]     c_init,
    input  logic [LENW-1:0] len,
    output logic [P-1:0]    dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            busy,
    output logic            done
);

    localparam int             WARM      = NC / P;
    localparam int             WCW       = (WARM > 1) ? $clog2(WARM) : 1;
    localparam logic [WCW-1:0] WARM_LAST = WCW'(WARM - 1);

    if ((P < 1) || (P > 28) || (NC < P) || ((NC % P) != 0)) begin : g_bad_param
        $error("nrs_gold_seq_gen: P must be 1..28 and divide NC");
    end

    gold_state_t     r_state;
    logic [WCW-1:0]  r_wcnt;
    logic [LENW-1:0] r_len_cnt;
    logic            r_valid;
    logic            r_busy;
    logic            r_done;

    logic [30:0]     w_s1;
    logic [30:0]     w_s2;
    logic            w_handshake;
    logic            w_adv;

    // r_valid is only ever set in RUN, so this is the RUN accept condition.
    assign w_handshake = r_valid & dout_ready;

    // start wins over a same-cycle handshake: the LFSRs reload instead.
    assign w_adv = !start && ((r_state == WARMUP) || w_handshake);

    nrs_lfsr31_par #(
        .P    (P),
        .TAPS (X1_TAPS)
    ) u_x1 (
        .clk        (clk),
        .rst        (rst),
        .i_load     (start),
        .i_load_val (X1_INIT),
        .i_adv      (w_adv),
        .o_state    (w_s1)
    );

    nrs_lfsr31_par #(
        .P    (P),
        .TAPS (X2_TAPS)
    ) u_x2 (
        .clk        (clk),
        .rst        (rst),
        .i_load     (start),
        .i_load_val (c_init),
        .i_adv      (w_adv),
        .o_state    (w_s2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_wcnt    <= '0;
            r_len_cnt <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                // Abort whatever is running; the aborted sequence gets no done.
                r_state   <= WARMUP;
                r_wcnt    <= '0;
                r_len_cnt <= len;
                r_valid   <= 1'b0;
                r_busy    <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                    end
                    WARMUP: begin
                        if (r_wcnt == WARM_LAST) begin
                            r_wcnt <= '0;
                            if (r_len_cnt != '0) begin
                                r_state <= RUN;
                                r_valid <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_wcnt <= r_wcnt + WCW'(1);
                        end
                    end
                    RUN: begin
                        if (w_handshake) begin
                            r_len_cnt <= r_len_cnt - LENW'(1);
                            if (r_len_cnt == LENW'(1)) begin
                                r_state <= IDLE;
                                r_valid <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        dout = '0;
        if (r_valid) begin
            dout = w_s1[P-1:0] ^ w_s2[P-1:0];
        end
    end

    assign dout_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_nrs_gold_seq_gen.sv
// tb/tb_nrs_gold_seq_gen.sv - self-checking bench for nrs_gold_seq_gen against a bit-serial Gold model

module tb_nrs_gold_seq_gen;

    localparam int P    = 8;
    localparam int NC   = 1600;
    localparam int LENW = 16;
    localparam int WARM = NC / P;
    localparam int GN   = 400;
    localparam int SP [4] = '{1, 4, 16, 25};

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [30:0]     c_init;
    logic [LENW-1:0] len;
    logic [P-1:0]    dout;
    logic            dout_valid;
    logic            dout_ready;
    logic            busy;
    logic            done;

    logic            s_start;
    logic [30:0]     s_c_init;
    logic [LENW-1:0] s_len;
    logic [31:0]     s_dout [4];
    logic [3:0]      s_valid;
    logic [3:0]      s_busy;
    logic [3:0]      s_done;

    int  nvec;
    int  nfail;
    bit  gold [GN];

    always #5 clk = ~clk;

    nrs_gold_seq_gen #(.P(P), .NC(NC), .LENW(LENW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .c_init     (c_init),
        .len        (len),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int PP = SP[g];
        logic [PP-1:0] w_d;
        logic          w_v;
        logic          w_b;
        logic          w_dn;
        nrs_gold_seq_gen #(.P(PP), .NC(NC), .LENW(LENW)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (s_start),
            .c_init     (s_c_init),
            .len        (s_len),
            .dout       (w_d),
            .dout_valid (w_v),
            .dout_ready (1'b1),
            .busy       (w_b),
            .done       (w_dn)
        );
        assign s_dout[g]  = 32'(w_d);
        assign s_valid[g] = w_v;
        assign s_busy[g]  = w_b;
        assign s_done[g]  = w_dn;
    end

    // Bit-serial reference: run both recursions bit by bit from their load
    // values and keep c(n) = x1(n+NC) ^ x2(n+NC) for n = 0 .. GN-1.
    task automatic make_gold(input logic [30:0] ci);
        bit x1 [NC+GN+31];
        bit x2 [NC+GN+31];
        for (int n = 0; n < 31; n++) begin
            x1[n] = (n == 0);
            x2[n] = ci[n];
        end
        for (int n = 0; n + 31 < NC + GN + 31; n++) begin
            x1[n+31] = x1[n+3] ^ x1[n];
            x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
        end
        for (int n = 0; n < GN; n++) begin
            gold[n] = x1[n+NC] ^ x2[n+NC];
        end
    endtask

    function automatic logic [31:0] gword(input int base, input int w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < w; b++) begin
            r[b] = gold[base+b];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Applies start at the current negedge; returns at the negedge after the load edge.
    task automatic do_start(input logic [30:0] ci, input int n);
        start  = 1'b1;
        c_init = ci;
        len    = LENW'(n);
        @(negedge clk);
        start  = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("valid_after_start", 32'(dout_valid), 32'd0);
    endtask

    // Collects n words starting right after do_start; k counts edges since the load edge.
    task automatic collect(input int n, input bit rnd, input bit fin);
        int          words;
        int          k;
        bit          seen;
        bit          stalled;
        bit          rdy;
        logic [P-1:0] held;
        words   = 0;
        k       = 0;
        seen    = 1'b0;
        stalled = 1'b0;
        held    = '0;
        while (words < n && k < WARM + 20 * n + 100) begin
            if (dout_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("first_valid_cycle", 32'(k), 32'(WARM));
                end
                if (stalled) begin
                    chk("stall_hold", 32'(dout), 32'(held));
                end
                chk("word", 32'(dout), gword(words * P, P));
            end
            chk("no_early_done", 32'(done), 32'd0);
            rdy        = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            dout_ready = rdy;
            stalled    = dout_valid && !rdy;
            held       = dout;
            if (dout_valid && rdy) begin
                words++;
            end
            @(negedge clk);
            k++;
        end
        chk("word_count", 32'(words), 32'(n));
        if (fin) begin
            chk("done_pulse", 32'(done), 32'd1);
            chk("busy_in_done", 32'(busy), 32'd0);
            chk("valid_in_done", 32'(dout_valid), 32'd0);
            chk("dout_in_done", 32'(dout), 32'd0);
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
        end else begin
            chk("no_done_partial", 32'(done), 32'd0);
            chk("valid_partial", 32'(dout_valid), 32'd1);
        end
    endtask

    logic [30:0] seed;
    logic [30:0] seed2;
    int          kk;
    bit          vseen;
    int          sw [4];
    int          sd [4];
    int          dsum;

    initial begin
        nvec       = 0;
        nfail      = 0;
        rst        = 1'b0;
        start      = 1'b0;
        c_init     = '0;
        len        = '0;
        dout_ready = 1'b0;
        s_start    = 1'b0;
        s_c_init   = '0;
        s_len      = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Golden: x2 = 0, so output is x1(1600..1631)
        make_gold(31'h0);
        dout_ready = 1'b1;
        do_start(31'h0, 4);
        collect(4, 1'b0, 1'b1);

        // Backpressure with a random seed
        seed = 31'($urandom);
        make_gold(seed);
        do_start(seed, 12);
        collect(12, 1'b1, 1'b1);

        // Restart while word 3 is on dout, with ready high in the same cycle
        seed = 31'($urandom);
        make_gold(seed);
        dout_ready = 1'b1;
        do_start(seed, 8);
        collect(3, 1'b0, 1'b0);
        seed2 = 31'($urandom);
        make_gold(seed2);
        dout_ready = 1'b1;
        do_start(seed2, 6);
        chk("restart_no_done", 32'(done), 32'd0);
        collect(6, 1'b1, 1'b1);

        // len = 0: done after warm-up, no valid word
        seed = 31'($urandom);
        do_start(seed, 0);
        kk    = 0;
        vseen = 1'b0;
        while (!done && kk < WARM + 20) begin
            vseen = vseen | dout_valid;
            @(negedge clk);
            kk++;
        end
        chk("len0_done_cycle", 32'(kk), 32'(WARM));
        chk("len0_no_valid", 32'(vseen), 32'd0);
        chk("len0_busy", 32'(busy), 32'd0);
        // start and reset together; reset wins
        start  = 1'b1;
        c_init = seed;
        len    = LENW'(3);
        rst    = 1'b0;
        #1;
        chk("rst_start_done_async", 32'(done), 32'd0);
        @(negedge clk);
        chk("rst_start_busy", 32'(busy), 32'd0);
        chk("rst_start_valid", 32'(dout_valid), 32'd0);
        chk("rst_start_dout", 32'(dout), 32'd0);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        chk("rst_start_busy_after", 32'(busy), 32'd0);

        // Async reset mid-WARMUP
        seed = 31'($urandom);
        make_gold(seed);
        do_start(seed, 5);
        repeat (50) @(negedge clk);
        chk("warm_busy_pre", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("warm_rst_busy", 32'(busy), 32'd0);
        chk("warm_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Async reset mid-RUN
        do_start(seed, 5);
        collect(2, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("run_rst_valid", 32'(dout_valid), 32'd0);
        chk("run_rst_dout", 32'(dout), 32'd0);
        chk("run_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("run_rst_no_done", 32'(done), 32'd0);
        do_start(seed, 5);
        collect(5, 1'b0, 1'b1);

        // Parameter sweep P = 1, 4, 16, 25
        s_c_init = 31'h12A5_F00D;
        s_len    = LENW'(10);
        make_gold(s_c_init);
        s_start  = 1'b1;
        @(negedge clk);
        s_start  = 1'b0;
        for (int g = 0; g < 4; g++) begin
            sw[g] = 0;
            sd[g] = 0;
        end
        kk   = 0;
        dsum = 0;
        while (dsum < 4 && kk < NC + 300) begin
            for (int g = 0; g < 4; g++) begin
                if (s_valid[g]) begin
                    chk($sformatf("sweep_word_p%0d", SP[g]), s_dout[g], gword(sw[g] * SP[g], SP[g]));
                    sw[g]++;
                end
                if (s_done[g]) begin
                    sd[g]++;
                    dsum++;
                    chk($sformatf("sweep_busy_p%0d", SP[g]), 32'(s_busy[g]), 32'd0);
                end
            end
            @(negedge clk);
            kk++;
        end
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("sweep_words_p%0d", SP[g]), 32'(sw[g]), 32'd10);
            chk($sformatf("sweep_dones_p%0d", SP[g]), 32'(sd[g]), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
